// File: rtl/hid_key_decoder.sv
// hid_key_decoder: turns 8-byte HID boot keyboard reports into one frame-stable keycode
//
// Optional feature macro: HID_STALE_TIMEOUT_EN (stale-report timeout; disabled when undefined)
//
// Ports:
//   Clk        in   system clock
//   Reset_n    in   synchronous active-low reset
//   rx_valid   in   input byte valid
//   rx_data    in   [7:0] report byte
//   rx_last    in   final byte of the report, qualified by rx_valid
//   rx_ready   out  decoder accepts a byte this cycle (low only in COMMIT)
//   frame_tick in   one-Clk pulse per video frame
//   keycode    out  [7:0] selected key, republished on frame_tick
//   modifiers  out  [7:0] byte 0 of the last committed report, republished on frame_tick
//   key_valid  out  keycode is nonzero
//   report_err out  one-cycle pulse per discarded report
module hid_key_decoder #(
    parameter int TIMEOUT_FRAMES  = 30,
    parameter int REJECT_ROLLOVER = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    input  logic       rx_last,
    output logic       rx_ready,
    input  logic       frame_tick,
    output logic [7:0] keycode,
    output logic [7:0] modifiers,
    output logic       key_valid,
    output logic       report_err
);
    typedef enum logic [2:0] {IDLE, MOD, RSVD, KEYS, COMMIT, DROP} state_t;

    state_t     state, state_nxt;
    logic [2:0] cnt;
    logic [7:0] stg_mod, stg_key, com_mod, com_key;
    logic       stg_rej, err_nxt, xfer;
`ifdef HID_STALE_TIMEOUT_EN
    logic [7:0] tmo;
`endif

    assign xfer      = rx_valid && rx_ready;
    assign key_valid = keycode != 8'h00;

    always_ff @(posedge Clk) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = rx_last ? IDLE : RSVD;
            RSVD:    if (xfer) state_nxt = rx_last ? IDLE : KEYS;
            KEYS:    if (xfer) state_nxt = cnt == 3'd7 ? (rx_last ? COMMIT : DROP) : (rx_last ? IDLE : KEYS);
            COMMIT:  state_nxt = IDLE;
            DROP:    if (xfer && rx_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Short reports error on an early rx_last; a long report errors once, on byte 7
    always_comb begin
        rx_ready = state != COMMIT;
        err_nxt  = state == COMMIT ? stg_rej :
                   state == KEYS   ? xfer && (cnt == 3'd7 ? !rx_last : rx_last) :
                   state == DROP   ? 1'b0 :
                                     xfer && rx_last;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt        <= '0;
            stg_mod    <= '0;
            stg_key    <= '0;
            stg_rej    <= 1'b0;
            com_mod    <= '0;
            com_key    <= '0;
            keycode    <= '0;
            modifiers  <= '0;
            report_err <= 1'b0;
`ifdef HID_STALE_TIMEOUT_EN
            tmo        <= '0;
`endif
        end else begin
            report_err <= err_nxt;
            if (xfer && state == IDLE) begin
                stg_mod <= rx_data;
                cnt     <= 3'd1;
            end
            if (xfer && state == RSVD) begin
                cnt     <= 3'd2;
                stg_key <= '0;
                stg_rej <= 1'b0;
            end
            if (xfer && state == KEYS) begin
                cnt <= cnt + 3'd1;
                if (stg_key == 8'h00 && rx_data > 8'h01) stg_key <= rx_data;
                if (REJECT_ROLLOVER != 0 && rx_data == 8'h01) stg_rej <= 1'b1;
            end
            // Publication samples the committed registers before any same-cycle commit
            if (frame_tick) begin
                keycode   <= com_key;
                modifiers <= com_mod;
            end
`ifdef HID_STALE_TIMEOUT_EN
            if (frame_tick && tmo != 8'hFF) tmo <= tmo + 8'd1;
            if (tmo >= 8'(TIMEOUT_FRAMES)) begin
                com_key <= '0;
                com_mod <= '0;
            end
`endif
            // A successful commit overrides the timeout clear and restarts the count
            if (state == COMMIT && !stg_rej) begin
                com_key <= stg_key;
                com_mod <= stg_mod;
`ifdef HID_STALE_TIMEOUT_EN
                tmo     <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_hid_key_decoder.sv
// tb_hid_key_decoder: scoreboard bench for the HID keycode decoder
module tb_hid_key_decoder;
    logic       Clk = 1'b0, Reset_n = 1'b0, rx_valid = 1'b0, rx_last = 1'b0, frame_tick = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready, key_valid, report_err;
    logic [7:0] keycode, modifiers;

    typedef logic [7:0] stream_t [10];

    int          cmps = 0, errs = 0, err_seen = 0, exp_errs = 0;
    logic [7:0]  m_key = 8'h00, m_mod = 8'h00;
    logic [15:0] exp_q [$];

    hid_key_decoder #(.TIMEOUT_FRAMES(3), .REJECT_ROLLOVER(1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_last(rx_last), .rx_ready(rx_ready), .frame_tick(frame_tick),
        .keycode(keycode), .modifiers(modifiers), .key_valid(key_valid),
        .report_err(report_err)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) if (report_err) err_seen++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] d, input bit l);
        int n = 0;
        @(negedge Clk);
        rx_valid = 1'b1; rx_data = d; rx_last = l;
        while (!rx_ready && n < 10) begin
            @(negedge Clk);
            n++;
        end
        if (!rx_ready) begin
            cmps++; errs++;
            $display("FAIL handshake: rx_ready=%b required 1 within 10 cycles", rx_ready);
        end
        @(posedge Clk);
        #1;
        rx_valid = 1'b0; rx_last = 1'b0;
    endtask

    // Drives a stream; complete 8-byte reports update the reference model and push
    // the value expected at the next publication
    task automatic send_stream(input stream_t b, input int len, input bit tick_on_commit);
        logic [7:0] k = 8'h00;
        bit         rej = 1'b0;
        for (int i = 0; i < len; i++) send_byte(b[i], i == len - 1);
        if (tick_on_commit) begin
            frame_tick = 1'b1;
            @(posedge Clk);
            #1;
            frame_tick = 1'b0;
        end
        if (len == 8) begin
            for (int i = 2; i < 8; i++) begin
                if (b[i] == 8'h01) rej = 1'b1;
                else if (k == 8'h00 && b[i] != 8'h00) k = b[i];
            end
            if (rej) exp_errs++;
            else begin
                m_key = k;
                m_mod = b[0];
            end
            exp_q.push_back({m_mod, m_key});
        end else exp_errs++;
        @(negedge Clk);
        @(negedge Clk);
    endtask

    task automatic tick_pop(output logic [15:0] e);
        @(negedge Clk);
        frame_tick = 1'b1;
        @(negedge Clk);
        frame_tick = 1'b0;
        if (exp_q.size() == 0) begin
            cmps++; errs++;
            e = 16'hxxxx;
            $display("FAIL scoreboard: queue size 0 required >0");
        end else e = exp_q.pop_front();
    endtask

    task automatic test_reset();
        repeat (2) @(negedge Clk);
        cmps += 5;
        if (keycode !== 8'h00)    begin errs++; $display("FAIL reset keycode: got %h required 00", keycode); end
        if (modifiers !== 8'h00)  begin errs++; $display("FAIL reset modifiers: got %h required 00", modifiers); end
        if (key_valid !== 1'b0)   begin errs++; $display("FAIL reset key_valid: got %b required 0", key_valid); end
        if (report_err !== 1'b0)  begin errs++; $display("FAIL reset report_err: got %b required 0", report_err); end
        if (rx_ready !== 1'b1)    begin errs++; $display("FAIL reset rx_ready: got %b required 1", rx_ready); end
        Reset_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] e;
        stream_t s = '{8'h00, 8'h00, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(s, 8, 1'b0);
        tick_pop(e);
        cmps += 4;
        if (keycode !== e[7:0])     begin errs++; $display("FAIL basic keycode: got %h required %h", keycode, e[7:0]); end
        if (modifiers !== e[15:8])  begin errs++; $display("FAIL basic modifiers: got %h required %h", modifiers, e[15:8]); end
        if (key_valid !== 1'b1)     begin errs++; $display("FAIL basic key_valid: got %b required 1", key_valid); end
        if (err_seen !== exp_errs)  begin errs++; $display("FAIL basic report_err count: got %0d required %0d", err_seen, exp_errs); end
    endtask

    task automatic test_first_wins();
        logic [15:0] e;
        stream_t s = '{8'h02, 8'h00, 8'h00, 8'h07, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(s, 8, 1'b0);
        tick_pop(e);
        cmps += 2;
        if (keycode !== e[7:0])    begin errs++; $display("FAIL first_wins keycode: got %h required %h", keycode, e[7:0]); end
        if (modifiers !== e[15:8]) begin errs++; $display("FAIL first_wins modifiers: got %h required %h", modifiers, e[15:8]); end
    endtask

    task automatic test_rollover();
        logic [15:0] e;
        stream_t a = '{8'h00, 8'h00, 8'h16, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        stream_t r = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00, 8'h00};
        send_stream(a, 8, 1'b0);
        tick_pop(e);
        cmps++;
        if (keycode !== e[7:0]) begin errs++; $display("FAIL rollover setup keycode: got %h required %h", keycode, e[7:0]); end
        send_stream(r, 8, 1'b0);
        tick_pop(e);
        cmps += 2;
        if (keycode !== e[7:0])    begin errs++; $display("FAIL rollover keycode: got %h required %h", keycode, e[7:0]); end
        if (err_seen !== exp_errs) begin errs++; $display("FAIL rollover report_err count: got %0d required %0d", err_seen, exp_errs); end
    endtask

    task automatic test_framing();
        logic [15:0] e;
        stream_t sh = '{8'h00, 8'h00, 8'h09, 8'h0A, 8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        stream_t lg = '{8'h00, 8'h00, 8'h0C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h0E};
        stream_t ok = '{8'h00, 8'h00, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(sh, 5, 1'b0);
        send_stream(lg, 10, 1'b0);
        exp_q.push_back({m_mod, m_key});
        tick_pop(e);
        cmps += 2;
        if (keycode !== e[7:0])    begin errs++; $display("FAIL framing keycode: got %h required %h", keycode, e[7:0]); end
        if (err_seen !== exp_errs) begin errs++; $display("FAIL framing report_err count: got %0d required %0d", err_seen, exp_errs); end
        send_stream(ok, 8, 1'b0);
        tick_pop(e);
        cmps++;
        if (keycode !== e[7:0]) begin errs++; $display("FAIL framing recovery keycode: got %h required %h", keycode, e[7:0]); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e;
        logic [7:0]  prev = m_key;
        stream_t s = '{8'h00, 8'h00, 8'h1A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(s, 8, 1'b1);
        cmps++;
        if (keycode !== prev) begin errs++; $display("FAIL coincident tick keycode: got %h required %h", keycode, prev); end
        tick_pop(e);
        cmps++;
        if (keycode !== e[7:0]) begin errs++; $display("FAIL following tick keycode: got %h required %h", keycode, e[7:0]); end
    endtask

    task automatic test_mid_reset();
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h2C, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        cmps += 4;
        if (keycode !== 8'h00)   begin errs++; $display("FAIL mid_reset keycode: got %h required 00", keycode); end
        if (modifiers !== 8'h00) begin errs++; $display("FAIL mid_reset modifiers: got %h required 00", modifiers); end
        if (key_valid !== 1'b0)  begin errs++; $display("FAIL mid_reset key_valid: got %b required 0", key_valid); end
        if (rx_ready !== 1'b1)   begin errs++; $display("FAIL mid_reset rx_ready: got %b required 1", rx_ready); end
        Reset_n = 1'b1;
        m_key = 8'h00;
        m_mod = 8'h00;
    endtask

    task automatic test_stale();
        logic [15:0] e;
        stream_t s = '{8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_stream(s, 8, 1'b0);
        exp_q.push_back({m_mod, m_key});
        exp_q.push_back({m_mod, m_key});
`ifdef HID_STALE_TIMEOUT_EN
        exp_q.push_back(16'h0000);
`else
        exp_q.push_back({m_mod, m_key});
`endif
        for (int t = 1; t <= 4; t++) begin
            tick_pop(e);
            cmps++;
            if (keycode !== e[7:0]) begin errs++; $display("FAIL stale tick %0d keycode: got %h required %h", t, keycode, e[7:0]); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_first_wins();
        test_rollover();
        test_framing();
        test_back_to_back();
        test_mid_reset();
        test_stale();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule

// File: doc/hid_key_decoder.md
Name: hid_key_decoder

Overview:
Parses 8-byte USB HID boot-protocol keyboard reports, delivered as a byte stream by the USB/SPI software bridge, into the single 8-bit keycode the ball motion logic consumes. It validates report framing, rejects ErrorRollOver reports and selects one active key. The keycode is republished only on frame-tick boundaries, so the ball sees a stable value for a whole frame.

Parameters:
TIMEOUT_FRAMES, 30, number of frame ticks without a committed report before the keycode is forced to 0x00 (used only with HID_STALE_TIMEOUT_EN).
REJECT_ROLLOVER, 1, 1: a report containing 0x01 in any key slot is discarded; 0: 0x01 slots are treated as empty.

Ports:
Clk  in  1  system clock
Reset_n  in  1  synchronous active-low reset
rx_valid  in  1  input byte valid
rx_data  in  8  report byte
rx_last  in  1  marks the final byte of the report; qualified by rx_valid
rx_ready  out  1  decoder accepts a byte this cycle
frame_tick  in  1  one-Clk pulse per video frame, already synchronous to Clk
keycode  out  8  selected key; feeds the ball keycode input
modifiers  out  8  byte 0 of the last committed report
key_valid  out  1  keycode is nonzero
report_err  out  1  one-cycle pulse on a discarded report

Behaviour:
- A byte transfers on a cycle where rx_valid && rx_ready.
- Reset (Reset_n=0 at a Clk edge) returns to IDLE and clears all of: keycode, modifiers, staged registers, byte counter, timeout counter, key_valid, report_err. rx_ready=1 after reset.
- Reset mid-report discards that report. Reset has priority over every other event.
- States: IDLE, MOD, RSVD, KEYS, COMMIT, DROP.
- IDLE: the first byte transferred goes to the staged modifier register; byte count becomes 1; next state RSVD. A byte with rx_last set here is a short report: pulse report_err, stay IDLE.
- RSVD: consume byte 1 without storing it; next state KEYS. rx_last set: short report -> report_err pulse, go to IDLE.
- KEYS: bytes 2..7.
  - Selection: the first nonzero, non-0x01 slot in arrival order is captured as the staged key. Staged key is 0x00 if no slot qualifies.
  - A 0x01 slot with REJECT_ROLLOVER=1 sets the staged reject flag.
  - rx_last on bytes 2..6: short report -> report_err pulse, go to IDLE.
  - Byte 7 with rx_last: go to COMMIT.
  - Byte 7 without rx_last: long report -> report_err pulse, go to DROP.
- COMMIT: lasts one cycle with rx_ready=0.
  - Reject flag set: report_err pulse; committed values unchanged.
  - Otherwise: staged key and modifiers are copied to the committed registers, and the timeout counter is cleared.
  - Next state IDLE.
- DROP: rx_ready=1; consume bytes until one with rx_last, then go to IDLE. No commit occurs.
- rx_ready=1 in every state except COMMIT.
- Publication: on a frame_tick cycle, keycode and modifiers load the committed registers, using their values at the start of that cycle.
  - A COMMIT in the same cycle as frame_tick becomes visible at the next frame_tick.
  - Latency from the last-byte handshake to keycode change is 2 Clk cycles minimum, up to one frame plus 2 cycles.
- key_valid = (keycode != 0), combinational from the registered keycode.
- report_err is registered, high for exactly one cycle per discarded report.

Optional Feature:
HID_STALE_TIMEOUT_EN
- Defined: an 8-bit saturating counter increments on each frame_tick and clears on each successful COMMIT. When it reaches TIMEOUT_FRAMES, the committed key and modifiers are cleared to 0x00, so keycode reads 0x00 at the next frame_tick. This guards against a hung bridge leaving the ball driven.
- Undefined: no counter exists; the last committed key is held indefinitely.

Test Plan:
- Report 00 00 1A 00 00 00 00 00 (rx_last on byte 7), then frame_tick -> keycode=0x1A, key_valid=1, modifiers=0x00; no report_err.
- Report 02 00 00 07 04 00 00 00 -> keycode=0x07 (first nonzero slot wins), modifiers=0x02 after the next frame_tick.
- Commit key 0x16, then send a report with bytes 2..7 all 0x01 (REJECT_ROLLOVER=1) -> one report_err pulse; keycode stays 0x16.
- rx_last on byte 4, then a 10-byte stream with rx_last on byte 9 -> two report_err pulses; keycode unchanged. A valid 0x04 report following these -> keycode=0x04.
- Last byte of a 0x1A report handshaked so COMMIT coincides with frame_tick -> keycode unchanged at that tick, 0x1A at the following tick. Assert Reset_n=0 mid-report -> all outputs 0x00 on the next cycle; rx_ready=1.
- HID_STALE_TIMEOUT_EN defined, TIMEOUT_FRAMES=3: commit 0x07, then 3 frame_ticks with no reports -> keycode=0x00 by the 4th tick. Same run with the macro undefined -> keycode stays 0x07.
